// File: rtl/usb_ctl_pipe0.sv
// EP0 control-pipe sequencer: captures SETUP, hands the request to a handler,
// packetises the descriptor stream into MPS-sized IN packets with replay on retry,
// and runs the status stage or STALL.
module usb_ctl_pipe0 #(
   parameter int MAX_PACKET_SIZE = 64,
   parameter int GNT_WAIT        = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        setup_i,
   input  logic        rx_tvalid_i,
   input  logic        rx_tlast_i,
   input  logic [7:0]  rx_tdata_i,
   input  logic        in_token_i,
   input  logic        out_token_i,
   input  logic        hsk_ack_i,
   output logic        tx_tvalid_o,
   input  logic        tx_tready_i,
   output logic        tx_tlast_o,
   output logic        tx_tkeep_o,
   output logic [7:0]  tx_tdata_o,
   output logic        stall_o,
   output logic [3:0]  ctl_xfer_endpoint,
   output logic [7:0]  ctl_xfer_type,
   output logic [7:0]  ctl_xfer_request,
   output logic [15:0] ctl_xfer_value,
   output logic [15:0] ctl_xfer_index,
   output logic [15:0] ctl_xfer_length,
   output logic        ctl_xfer_req_o,
   input  logic        ctl_xfer_gnt_i,
   input  logic        ctl_tvalid_i,
   output logic        ctl_tready_o,
   input  logic        ctl_tlast_i,
   input  logic [7:0]  ctl_tdata_i
);

   localparam int         AW      = $clog2(MAX_PACKET_SIZE);
   localparam logic [6:0] MPS     = 7'(MAX_PACKET_SIZE);
   localparam logic [7:0] GW_LAST = 8'(GNT_WAIT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_SETUP, S_REQ, S_FILL, S_XMIT, S_WAIT_ACK, S_STATUS_OUT, S_STATUS_IN, S_STALL
   } state_e;

   state_e      state_q, state_d;
   logic        req_q, req_d;
   logic [7:0]  type_q, type_d, request_q, request_d;
   logic [15:0] value_q, value_d, index_q, index_d, length_q, length_d;
   logic [15:0] remaining_q, remaining_d;
   logic [6:0]  pkt_len_q, pkt_len_d;
   logic        desc_end_q, desc_end_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  wait_q, wait_d;
   logic        active_q, active_d;
   logic [6:0]  idx_q, idx_d;

   logic [7:0]    buf_mem [MAX_PACKET_SIZE];
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic [6:0]    limit;
   logic [15:0]   rem_after;

   // Packet size limit and saturating remaining-length update
   always_comb begin
      limit     = (remaining_q >= 16'(MAX_PACKET_SIZE)) ? MPS : remaining_q[6:0];
      rem_after = (remaining_q > 16'(pkt_len_q)) ? (remaining_q - 16'(pkt_len_q)) : '0;
   end

   // Output decode from registered state
   always_comb begin
      tx_tvalid_o       = active_q;
      tx_tkeep_o        = (pkt_len_q != '0);
      tx_tlast_o        = (pkt_len_q == '0) || (idx_q == pkt_len_q - 7'd1);
      tx_tdata_o        = buf_mem[idx_q[AW-1:0]];
      ctl_tready_o      = (state_q == S_FILL) && !desc_end_q && (pkt_len_q < limit);
      stall_o           = (state_q == S_STALL);
      ctl_xfer_req_o    = req_q;
      ctl_xfer_endpoint = '0;
      ctl_xfer_type     = type_q;
      ctl_xfer_request  = request_q;
      ctl_xfer_value    = value_q;
      ctl_xfer_index    = index_q;
      ctl_xfer_length   = length_q;
   end

   // Next-state logic for the control-transfer sequencer
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      type_d      = type_q;
      request_d   = request_q;
      value_d     = value_q;
      index_d     = index_q;
      length_d    = length_q;
      remaining_d = remaining_q;
      pkt_len_d   = pkt_len_q;
      desc_end_d  = desc_end_q;
      cnt_d       = cnt_q;
      wait_d      = wait_q;
      active_d    = active_q;
      idx_d       = idx_q;
      wr_en       = 1'b0;
      wr_addr     = pkt_len_q[AW-1:0];
      wr_data     = ctl_tdata_i;
      if (setup_i) begin
         state_d  = S_SETUP;
         req_d    = 1'b0;
         active_d = 1'b0;
         cnt_d    = '0;
      end else begin
         case (state_q)
            S_SETUP: if (rx_tvalid_i) begin
               if (cnt_q < 4'd8) begin
                  case (cnt_q[2:0])
                     3'd0: type_d          = rx_tdata_i;
                     3'd1: request_d       = rx_tdata_i;
                     3'd2: value_d[7:0]    = rx_tdata_i;
                     3'd3: value_d[15:8]   = rx_tdata_i;
                     3'd4: index_d[7:0]    = rx_tdata_i;
                     3'd5: index_d[15:8]   = rx_tdata_i;
                     3'd6: length_d[7:0]   = rx_tdata_i;
                     default: length_d[15:8] = rx_tdata_i;
                  endcase
               end
               if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
               if (rx_tlast_i) begin
                  if (cnt_q == 4'd7) begin
                     state_d = S_REQ;
                     req_d   = 1'b1;
                     wait_d  = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            S_REQ: if (ctl_xfer_gnt_i) begin
               remaining_d = length_q;
               pkt_len_d   = '0;
               desc_end_d  = 1'b0;
               if (length_q == '0) state_d = S_STATUS_IN;
               else if (type_q[7]) state_d = S_FILL;
               else begin
                  state_d = S_STALL;
                  req_d   = 1'b0;
               end
            end else if (wait_q >= GW_LAST) begin
               state_d = S_STALL;
               req_d   = 1'b0;
            end else begin
               wait_d = wait_q + 8'd1;
            end
            S_FILL: if (desc_end_q || pkt_len_q >= limit) begin
               state_d = S_XMIT;
            end else if (ctl_tvalid_i) begin
               wr_en     = 1'b1;
               pkt_len_d = pkt_len_q + 7'd1;
               if (ctl_tlast_i) desc_end_d = 1'b1;
               if (ctl_tlast_i || (pkt_len_q + 7'd1 == limit)) state_d = S_XMIT;
            end
            S_XMIT: if (active_q) begin
               if (tx_tready_i) begin
                  if (tx_tlast_o) begin
                     active_d = 1'b0;
                     state_d  = S_WAIT_ACK;
                  end else begin
                     idx_d = idx_q + 7'd1;
                  end
               end
            end else if (in_token_i) begin
               active_d = 1'b1;
               idx_d    = '0;
            end
            S_WAIT_ACK: if (hsk_ack_i) begin
               remaining_d = rem_after;
               if (rem_after == '0 || pkt_len_q < MPS) begin
                  state_d = S_STATUS_OUT;
               end else begin
                  pkt_len_d = '0;
                  state_d   = S_FILL;
               end
            end else if (in_token_i) begin
               // retry: the buffer still holds the unacknowledged packet
               state_d  = S_XMIT;
               active_d = 1'b1;
               idx_d    = '0;
            end
            // Entry here always follows an ACK, so the last data packet is
            // acknowledged and an IN token has nothing to resend.
            S_STATUS_OUT: if (out_token_i) begin
               req_d   = 1'b0;
               state_d = S_IDLE;
            end
            // pkt_len is zero here, so the single beat goes out as a ZLP
            S_STATUS_IN: if (active_q) begin
               if (tx_tready_i) active_d = 1'b0;
            end else if (in_token_i) begin
               active_d = 1'b1;
               idx_d    = '0;
            end else if (hsk_ack_i) begin
               req_d   = 1'b0;
               state_d = S_IDLE;
            end
            S_IDLE, S_STALL: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         req_q       <= 1'b0;
         type_q      <= '0;
         request_q   <= '0;
         value_q     <= '0;
         index_q     <= '0;
         length_q    <= '0;
         remaining_q <= '0;
         pkt_len_q   <= '0;
         desc_end_q  <= 1'b0;
         cnt_q       <= '0;
         wait_q      <= '0;
         active_q    <= 1'b0;
         idx_q       <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         type_q      <= type_d;
         request_q   <= request_d;
         value_q     <= value_d;
         index_q     <= index_d;
         length_q    <= length_d;
         remaining_q <= remaining_d;
         pkt_len_q   <= pkt_len_d;
         desc_end_q  <= desc_end_d;
         cnt_q       <= cnt_d;
         wait_q      <= wait_d;
         active_q    <= active_d;
         idx_q       <= idx_d;
      end
   end

   // Replay buffer write port
   always_ff @(posedge clock) begin
      if (wr_en) buf_mem[wr_addr] <= wr_data;
   end

endmodule

// File: tb/tb_usb_ctl_pipe0.sv
// Directed bench for usb_ctl_pipe0: IN beats are checked by a scoreboard monitor,
// control signals by direct checks.
module tb_usb_ctl_pipe0;

   logic        clock = 1'b0, reset_n = 1'b0;
   logic        setup_i = 1'b0, rx_tvalid_i = 1'b0, rx_tlast_i = 1'b0;
   logic [7:0]  rx_tdata_i = '0;
   logic        in_token_i = 1'b0, out_token_i = 1'b0, hsk_ack_i = 1'b0;
   logic        tx_tvalid_o, tx_tready_i = 1'b1, tx_tlast_o, tx_tkeep_o;
   logic [7:0]  tx_tdata_o;
   logic        stall_o;
   logic [3:0]  ctl_xfer_endpoint;
   logic [7:0]  ctl_xfer_type, ctl_xfer_request;
   logic [15:0] ctl_xfer_value, ctl_xfer_index, ctl_xfer_length;
   logic        ctl_xfer_req_o, ctl_xfer_gnt_i;
   logic        ctl_tvalid_i, ctl_tready_o, ctl_tlast_i;
   logic [7:0]  ctl_tdata_i;

   usb_ctl_pipe0 #(.MAX_PACKET_SIZE(64), .GNT_WAIT(2)) dut (
      .clock(clock), .reset_n(reset_n), .setup_i(setup_i),
      .rx_tvalid_i(rx_tvalid_i), .rx_tlast_i(rx_tlast_i), .rx_tdata_i(rx_tdata_i),
      .in_token_i(in_token_i), .out_token_i(out_token_i), .hsk_ack_i(hsk_ack_i),
      .tx_tvalid_o(tx_tvalid_o), .tx_tready_i(tx_tready_i), .tx_tlast_o(tx_tlast_o),
      .tx_tkeep_o(tx_tkeep_o), .tx_tdata_o(tx_tdata_o), .stall_o(stall_o),
      .ctl_xfer_endpoint(ctl_xfer_endpoint), .ctl_xfer_type(ctl_xfer_type),
      .ctl_xfer_request(ctl_xfer_request), .ctl_xfer_value(ctl_xfer_value),
      .ctl_xfer_index(ctl_xfer_index), .ctl_xfer_length(ctl_xfer_length),
      .ctl_xfer_req_o(ctl_xfer_req_o), .ctl_xfer_gnt_i(ctl_xfer_gnt_i),
      .ctl_tvalid_i(ctl_tvalid_i), .ctl_tready_o(ctl_tready_o),
      .ctl_tlast_i(ctl_tlast_i), .ctl_tdata_i(ctl_tdata_i)
   );

   always #5 clock = ~clock;

   int errors = 0, checks = 0;

   // request handler model: grants when enabled, streams h_len descriptor bytes
   logic       gnt_en = 1'b0, h_load = 1'b0;
   int         h_len = 0, h_idx = 0;
   logic [7:0] h_seed = '0;

   function automatic logic [7:0] dbyte(input int i, input logic [7:0] s);
      return 8'(i * 13 + 5) ^ s;
   endfunction

   assign ctl_xfer_gnt_i = gnt_en & ctl_xfer_req_o;
   assign ctl_tvalid_i   = (h_idx < h_len);
   assign ctl_tdata_i    = dbyte(h_idx, h_seed);
   assign ctl_tlast_i    = (h_idx == h_len - 1);

   always @(posedge clock) begin
      if (h_load) h_idx <= 0;
      else if (ctl_tvalid_i && ctl_tready_o) h_idx <= h_idx + 1;
   end

   typedef struct packed { logic [7:0] d; logic k; logic l; } beat_t;
   beat_t sb[$];
   beat_t exp_b;
   logic       hold_pend = 1'b0;
   logic [7:0] hold_d = '0;

   // monitor: every accepted IN beat must match the head of the scoreboard
   always @(negedge clock) begin
      if (!reset_n) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            checks++;
            if (!tx_tvalid_o || tx_tdata_o !== hold_d) begin
               errors++;
               $display("FAIL beat_hold: valid=%b data=%02h, required valid=1 data=%02h",
                        tx_tvalid_o, tx_tdata_o, hold_d);
            end
         end
         hold_pend = tx_tvalid_o && !tx_tready_i;
         hold_d    = tx_tdata_o;
         if (tx_tvalid_o && tx_tready_i) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: data=%02h keep=%b last=%b, required no beat",
                        tx_tdata_o, tx_tkeep_o, tx_tlast_o);
            end else begin
               exp_b = sb.pop_front();
               if (tx_tkeep_o !== exp_b.k || tx_tlast_o !== exp_b.l ||
                   (exp_b.k && tx_tdata_o !== exp_b.d)) begin
                  errors++;
                  $display("FAIL beat: data=%02h keep=%b last=%b, required data=%02h keep=%b last=%b",
                           tx_tdata_o, tx_tkeep_o, tx_tlast_o, exp_b.d, exp_b.k, exp_b.l);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic push_pkt(input int n, input logic [7:0] s);
      beat_t b;
      if (n == 0) begin
         b.d = '0; b.k = 1'b0; b.l = 1'b1;
         sb.push_back(b);
      end else begin
         for (int i = 0; i < n; i++) begin
            b.d = dbyte(i, s); b.k = 1'b1; b.l = (i == n - 1);
            sb.push_back(b);
         end
      end
   endtask

   task automatic wait_sb(input string name, input int budget);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d beats still pending, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic pulse_setup();
      setup_i = 1'b1; tick(); setup_i = 1'b0;
   endtask

   task automatic send_bytes(input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         rx_tvalid_i = 1'b1;
         rx_tdata_i  = v[8*i +: 8];
         rx_tlast_i  = (i == n - 1);
         tick();
      end
      rx_tvalid_i = 1'b0;
      rx_tlast_i  = 1'b0;
   endtask

   task automatic do_setup(input logic [63:0] v, input int n);
      pulse_setup();
      send_bytes(v, n);
   endtask

   task automatic pulse_in();  in_token_i  = 1'b1; tick(); in_token_i  = 1'b0; endtask
   task automatic pulse_out(); out_token_i = 1'b1; tick(); out_token_i = 1'b0; endtask
   task automatic pulse_ack(); hsk_ack_i   = 1'b1; tick(); hsk_ack_i   = 1'b0; endtask

   task automatic load_handler(input int n, input logic [7:0] s);
      h_len = n; h_seed = s; h_load = 1'b1; tick(); h_load = 1'b0;
   endtask

   initial begin
      // reset state
      tick(2);
      chk("rst_req", 32'(ctl_xfer_req_o), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_tvalid", 32'(tx_tvalid_o), 32'd0);
      chk("rst_ctl_tready", 32'(ctl_tready_o), 32'd0);
      chk("rst_length", 32'(ctl_xfer_length), 32'd0);
      reset_n = 1'b1;
      tick();

      // GET_DESCRIPTOR length 0x40, 18-byte descriptor, IN held by backpressure
      gnt_en = 1'b1;
      load_handler(18, 8'h00);
      do_setup(64'h0040000001000680, 8);
      chk("t1_req", 32'(ctl_xfer_req_o), 32'd1);
      chk("t1_type", 32'(ctl_xfer_type), 32'h80);
      chk("t1_request", 32'(ctl_xfer_request), 32'h06);
      chk("t1_value", 32'(ctl_xfer_value), 32'h0100);
      chk("t1_index", 32'(ctl_xfer_index), 32'h0);
      chk("t1_length", 32'(ctl_xfer_length), 32'h40);
      chk("t1_endpoint", 32'(ctl_xfer_endpoint), 32'h0);
      tick(30);
      chk("t1_fill_count", 32'(h_idx), 32'd18);
      tx_tready_i = 1'b0;
      push_pkt(18, 8'h00);
      pulse_in();
      tick(3);
      tx_tready_i = 1'b1;
      wait_sb("t1_pkt", 100);
      tick(2);
      pulse_ack();
      tick(2);
      chk("t1_req_status", 32'(ctl_xfer_req_o), 32'd1);
      pulse_out();
      chk("t1_req_fall", 32'(ctl_xfer_req_o), 32'd0);

      // length 8 truncates an 18-byte descriptor
      load_handler(18, 8'h5A);
      do_setup(64'h0008000001000680, 8);
      tick(20);
      chk("t2_fill_count", 32'(h_idx), 32'd8);
      push_pkt(8, 8'h5A);
      pulse_in();
      wait_sb("t2_pkt", 50);
      tick(2);
      pulse_ack();
      tick(3);
      chk("t2_no_overread", 32'(h_idx), 32'd8);
      pulse_out();
      chk("t2_req_fall", 32'(ctl_xfer_req_o), 32'd0);

      // 64-byte descriptor, length 0xFF: full packet then ZLP
      load_handler(64, 8'hC3);
      do_setup(64'h00FF000002000680, 8);
      tick(80);
      chk("t3_fill_count", 32'(h_idx), 32'd64);
      push_pkt(64, 8'hC3);
      pulse_in();
      wait_sb("t3_pkt", 200);
      tick(2);
      pulse_ack();
      tick(3);
      push_pkt(0, 8'h00);
      pulse_in();
      wait_sb("t3_zlp", 20);
      tick(2);
      pulse_ack();
      tick(2);
      chk("t3_req_status", 32'(ctl_xfer_req_o), 32'd1);
      chk("t3_no_overread", 32'(h_idx), 32'd64);
      pulse_out();
      chk("t3_req_fall", 32'(ctl_xfer_req_o), 32'd0);

      // SET_ADDRESS: no data stage, status IN ZLP
      load_handler(0, 8'h00);
      do_setup(64'h0000000000070500, 8);
      chk("t4_req", 32'(ctl_xfer_req_o), 32'd1);
      chk("t4_value", 32'(ctl_xfer_value), 32'h0007);
      tick(3);
      push_pkt(0, 8'h00);
      pulse_in();
      wait_sb("t4_zlp", 20);
      tick(2);
      chk("t4_req_hold", 32'(ctl_xfer_req_o), 32'd1);
      pulse_ack();
      chk("t4_req_fall", 32'(ctl_xfer_req_o), 32'd0);

      // no grant: STALL after GNT_WAIT cycles, next SETUP clears it
      gnt_en = 1'b0;
      do_setup(64'h0040000003000680, 8);
      chk("t5_req", 32'(ctl_xfer_req_o), 32'd1);
      tick();
      chk("t5_stall_early", 32'(stall_o), 32'd0);
      tick();
      chk("t5_stall", 32'(stall_o), 32'd1);
      chk("t5_req_drop", 32'(ctl_xfer_req_o), 32'd0);
      pulse_in();
      tick(3);
      chk("t5_stall_hold", 32'(stall_o), 32'd1);
      pulse_setup();
      chk("t5_stall_clear", 32'(stall_o), 32'd0);
      // 7-byte SETUP is discarded
      send_bytes(64'h0040000001000680, 7);
      chk("t6_no_req", 32'(ctl_xfer_req_o), 32'd0);
      tick(4);
      chk("t6_no_req_late", 32'(ctl_xfer_req_o), 32'd0);

      // retry without ACK replays the same bytes; handler read once
      gnt_en = 1'b1;
      load_handler(10, 8'h3C);
      do_setup(64'h0012000001000680, 8);
      tick(15);
      push_pkt(10, 8'h3C);
      pulse_in();
      wait_sb("t7_pkt", 50);
      tick(2);
      push_pkt(10, 8'h3C);
      pulse_in();
      wait_sb("t7_replay", 50);
      tick(2);
      chk("t7_read_once", 32'(h_idx), 32'd10);
      pulse_ack();
      tick(2);
      pulse_in();
      tick(4);
      chk("t7_status_in_ignored", 32'(tx_tvalid_o), 32'd0);
      chk("t7_req_status", 32'(ctl_xfer_req_o), 32'd1);
      pulse_out();
      chk("t7_req_fall", 32'(ctl_xfer_req_o), 32'd0);

      // host-to-device request with data stage is stalled on grant
      load_handler(0, 8'h00);
      do_setup(64'h0004000000010900, 8);
      tick();
      chk("t8_stall", 32'(stall_o), 32'd1);
      chk("t8_req_drop", 32'(ctl_xfer_req_o), 32'd0);

      // reset in the middle of a held IN beat
      load_handler(20, 8'h77);
      do_setup(64'h0040000001000680, 8);
      tick(25);
      tx_tready_i = 1'b0;
      pulse_in();
      tick(2);
      chk("t9_beat_presented", 32'(tx_tvalid_o), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("t9_rst_tvalid", 32'(tx_tvalid_o), 32'd0);
      chk("t9_rst_req", 32'(ctl_xfer_req_o), 32'd0);
      chk("t9_rst_length", 32'(ctl_xfer_length), 32'd0);
      tick();
      reset_n = 1'b1;
      tx_tready_i = 1'b1;
      tick();
      pulse_in();
      tick(5);
      chk("t9_no_beat", 32'(tx_tvalid_o), 32'd0);
      chk("t9_ctl_tready", 32'(ctl_tready_o), 32'd0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/usb_ctl_pipe0.md
USB_CTL_PIPE0 -- requirements
Module: usb_ctl_pipe0

Interface
REQ-001 SHALL have parameter MAX_PACKET_SIZE, default 64, meaning EP0 max IN payload bytes (8, 16, 32 or 64).
REQ-002 SHALL have parameter GNT_WAIT, default 2, meaning cycles after req assertion by which gnt must be seen.
REQ-003 clock  in  1  sole clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 setup_i  in  1  one-cycle pulse: SETUP token for EP0 decoded.
REQ-006 rx_tvalid_i / rx_tlast_i / rx_tdata_i  in  1/1/8  DATA0 payload after SETUP, CRC stripped; always accepted.
REQ-007 in_token_i / out_token_i / hsk_ack_i  in  1/1/1  one-cycle pulses: IN token, OUT token, host ACK.
REQ-008 tx_tvalid_o / tx_tready_i / tx_tlast_o / tx_tkeep_o / tx_tdata_o  out/in/out/out/out  1/1/1/1/8  IN payload to packet encoder; tkeep=0 on a last beat means zero-length packet (ZLP).
REQ-009 stall_o  out  1  level: encoder answers EP0 tokens with STALL.
REQ-010 ctl_xfer_endpoint/type/request/value/index/length  out  4/8/8/16/16/16  decoded SETUP fields to request handler.
REQ-011 ctl_xfer_req_o / ctl_xfer_gnt_i  out/in  1/1  request/grant to request handler.
REQ-012 ctl_tvalid_i / ctl_tready_o / ctl_tlast_i / ctl_tdata_i  in/out/in/in  1/1/1/8  descriptor stream from request handler.

Function
REQ-013 States SHALL be IDLE, SETUP, REQ, FILL, XMIT, WAIT_ACK, STATUS_OUT, STATUS_IN, STALL.
REQ-014 setup_i in any state SHALL clear stall_o, deassert ctl_xfer_req_o and tx_tvalid_o next cycle, and enter SETUP.
REQ-015 SETUP: bytes 0..7 captured as type, request, value[7:0], value[15:8], index LE, length LE; endpoint fixed 0.
REQ-016 SETUP ending (rx_tlast_i) with byte count != 8 SHALL return to IDLE, no req.
REQ-017 8-byte SETUP SHALL assert ctl_xfer_req_o the cycle after the last byte and enter REQ; fields stable while req high.
REQ-018 REQ: gnt not seen within GNT_WAIT cycles -> STALL, req deasserted.
REQ-019 REQ granted: type[7]=1 and length>0 -> FILL; length=0 -> STATUS_IN; type[7]=0 and length>0 -> STALL.
REQ-020 ctl_xfer_req_o SHALL stay high from grant until status stage completes (handler commits address/configuration on its fall).
REQ-021 remaining: 16-bit counter loaded with length on grant; pkt_len: 7-bit; buffer: MAX_PACKET_SIZE x 8 replay RAM.
REQ-022 FILL: ctl_tready_o=1; each accepted beat written at pkt_len, pkt_len+1; stop when pkt_len=min(MPS, remaining) or beat with ctl_tlast_i (sets desc_end); then XMIT-wait.
REQ-023 FILL with desc_end already set SHALL accept no beats, pkt_len=0.
REQ-024 XMIT on in_token_i: stream buffer[0..pkt_len-1], tx_tkeep_o=1, tx_tlast_o on final beat; pkt_len=0 -> single beat tkeep=0 tlast=1; hold beat while tx_tready_i low.
REQ-025 WAIT_ACK: hsk_ack_i -> remaining -= pkt_len; remaining=0 or pkt_len<MPS -> STATUS_OUT, else pkt_len cleared, FILL.
REQ-026 WAIT_ACK: in_token_i without prior ACK SHALL replay identical buffer (retry), handler not read.
REQ-027 Resulting rule: descriptor shorter than length and exact multiple of MPS SHALL end with one ZLP.
REQ-028 STATUS_OUT: out_token_i -> req deasserted, IDLE. in_token_i -> ZLP resent only if last packet unacked, else ignored.
REQ-029 STATUS_IN: in_token_i -> ZLP; hsk_ack_i -> req deasserted, IDLE.
REQ-030 STALL: stall_o=1, req=0, tokens ignored until setup_i.
REQ-031 Length arithmetic SHALL never underflow; data beyond length never read from handler.

Reset
REQ-032 reset_n low SHALL asynchronously force IDLE; stall_o, ctl_xfer_req_o, tx_tvalid_o, ctl_tready_o = 0; all ctl_xfer fields, remaining, pkt_len = 0; desc_end clear.
REQ-033 Reset mid-transfer SHALL discard buffer contents; no output beat after release until a new SETUP.

Verification
REQ-034 SETUP 80 06 00 01 00 00 40 00, handler grants, 18-byte stream -> one 18-byte IN packet, OUT status -> req falls, IDLE.
REQ-035 Same with length=0x0008 -> exactly 8 bytes sent, last with tlast, handler ctl_tready_o never high after 8th beat.
REQ-036 GET_DESCRIPTOR length=0xFF, 64-byte stream, MPS=64 -> 64-byte packet, ACK, then ZLP (tkeep=0), ACK, STATUS_OUT.
REQ-037 SETUP 00 05 07 00 00 00 00 00 -> STATUS_IN ZLP on IN, req stays high until hsk_ack_i, then falls.
REQ-038 Unsupported request (gnt never rises) -> stall_o=1 after GNT_WAIT cycles; next setup_i clears stall_o.
REQ-039 Second in_token_i without ACK -> byte-identical packet replayed; 7-byte SETUP -> no req.
